// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

    // Level of the reset input that holds the FIFO in reset.
    localparam logic RST_ACTIVE = 1'b0;

    // Read-mode selectors for the FWFT parameter.
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Ceiling log2 used to size addresses from a depth.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store the incoming word at the write address on an accepted write.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_param_ctrl.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and a selectable standard or FWFT read mode.
module fifo_param_ctrl
    import fifo_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  DEPTH    = 16,
    parameter int  AF_LEVEL = 14,
    parameter int  AE_LEVEL = 2,
    parameter int  FWFT     = 0,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_param_ctrl: DEPTH must be a power of 2 and at least 4");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_param_ctrl: AF_LEVEL must lie in 0..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
        $error("fifo_param_ctrl: AE_LEVEL must lie in 0..DEPTH");
    end

    localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT = AE_LEVEL[ADDR_W:0];

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              r_udf;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic [DATA_W-1:0] w_head;

    // Decide which requests are accepted and where pointers and count go next;
    // a pop frees a slot, so a write into a full FIFO is allowed alongside it.
    always_comb begin
        w_rd_acc     = read_en & ~r_empty;
        w_wr_acc     = write_en & (~r_full | w_rd_acc);
        w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + 1'b1 : r_wr_ptr;
        w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_count_nxt  = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Register pointers, count and all status flags from the same next state
    // so every flag agrees with count in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RST_ACTIVE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= (AF_LEVEL == 0);
            r_ae     <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                        (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_af     <= (w_count_nxt >= AF_CNT);
            r_ae     <= (w_count_nxt <= AE_CNT);
        end
    end

    // Sticky error flags; a new error event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RST_ACTIVE) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (write_en & ~w_wr_acc) | (r_ovf & ~clr_err);
            r_udf <= (read_en & r_empty) | (r_udf & ~clr_err);
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_head)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        // Head entry is shown directly; forced to zero while empty so reset
        // and an empty FIFO never expose stale storage.
        assign data_out   = r_empty ? '0 : w_head;
        assign data_valid = ~r_empty;
    end else begin : g_std
        logic [DATA_W-1:0] r_dout;
        logic              r_dvalid;

        // Capture the head on an accepted pop and pulse valid for that one cycle.
        always_ff @(posedge clk or negedge reset) begin
            if (reset == RST_ACTIVE) begin
                r_dout   <= '0;
                r_dvalid <= 1'b0;
            end else begin
                r_dvalid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= w_head;
                end
            end
        end

        assign data_out   = r_dout;
        assign data_valid = r_dvalid;
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Directed bench for fifo_param_ctrl: one standard-mode and one FWFT instance.
module tb_fifo_param_ctrl;

    logic       clk;
    logic       rstN;

    logic       writeEn, readEn, clrErr;
    logic [7:0] dataIn, dataOut;
    logic       dataValid, full, empty, almostFull, almostEmpty, overflow, underflow;
    logic [4:0] count;

    logic       fWriteEn, fReadEn, fClrErr;
    logic [7:0] fDataIn, fDataOut;
    logic       fDataValid, fFull, fEmpty, fAlmostFull, fAlmostEmpty, fOverflow, fUnderflow;
    logic [4:0] fCount;

    int checks;
    int passes;
    logic [7:0] model[$];
    logic [7:0] expByte;

    fifo_param_ctrl #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dutStd (
        .clk(clk), .reset(rstN), .write_en(writeEn), .data_in(dataIn), .read_en(readEn),
        .clr_err(clrErr), .data_out(dataOut), .data_valid(dataValid), .full(full),
        .empty(empty), .almost_full(almostFull), .almost_empty(almostEmpty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_param_ctrl #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dutFwft (
        .clk(clk), .reset(rstN), .write_en(fWriteEn), .data_in(fDataIn), .read_en(fReadEn),
        .clr_err(fClrErr), .data_out(fDataOut), .data_valid(fDataValid), .full(fFull),
        .empty(fEmpty), .almost_full(fAlmostFull), .almost_empty(fAlmostEmpty),
        .count(fCount), .overflow(fOverflow), .underflow(fUnderflow)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values while reset is held low.
    task automatic test_reset();
        checks++; if (count !== 5'd0) $display("[TB] FAIL rst_count: got %0d expected 0", count); else passes++;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL rst_empty: got %b expected 1", empty); else passes++;
        checks++; if (full !== 1'b0) $display("[TB] FAIL rst_full: got %b expected 0", full); else passes++;
        checks++; if (almostFull !== 1'b0) $display("[TB] FAIL rst_af: got %b expected 0", almostFull); else passes++;
        checks++; if (almostEmpty !== 1'b1) $display("[TB] FAIL rst_ae: got %b expected 1", almostEmpty); else passes++;
        checks++; if (dataOut !== 8'h00) $display("[TB] FAIL rst_dout: got %h expected 00", dataOut); else passes++;
        checks++; if (dataValid !== 1'b0) $display("[TB] FAIL rst_dvalid: got %b expected 0", dataValid); else passes++;
        checks++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL rst_err: got %b expected 00", {overflow, underflow}); else passes++;
        checks++; if (fDataValid !== 1'b0) $display("[TB] FAIL rst_fwft_dvalid: got %b expected 0", fDataValid); else passes++;
    endtask

    // Sixteen writes fill the FIFO; a seventeenth is rejected and flags overflow.
    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            writeEn = 1'b1; dataIn = 8'(i);
            tick();
            checks++; if (count !== 5'(i + 1)) $display("[TB] FAIL fill_count: got %0d expected %0d", count, i + 1); else passes++;
            checks++; if (almostFull !== (i + 1 >= 14)) $display("[TB] FAIL fill_af: got %b at count %0d", almostFull, i + 1); else passes++;
            checks++; if (full !== (i + 1 == 16)) $display("[TB] FAIL fill_full: got %b at count %0d", full, i + 1); else passes++;
            checks++; if (almostEmpty !== (i + 1 <= 2)) $display("[TB] FAIL fill_ae: got %b at count %0d", almostEmpty, i + 1); else passes++;
            checks++; if (overflow !== 1'b0) $display("[TB] FAIL fill_ovf: got %b expected 0", overflow); else passes++;
        end
        dataIn = 8'hAA;
        tick();
        writeEn = 1'b0;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL fill_extra_ovf: got %b expected 1", overflow); else passes++;
        checks++; if (count !== 5'd16) $display("[TB] FAIL fill_extra_count: got %0d expected 16", count); else passes++;
    endtask

    // Drain in order with one-cycle valid pulses, then underflow and clear.
    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            readEn = 1'b1;
            tick();
            checks++; if (dataOut !== 8'(i)) $display("[TB] FAIL drain_data: got %h expected %h", dataOut, 8'(i)); else passes++;
            checks++; if (dataValid !== 1'b1) $display("[TB] FAIL drain_valid: got %b expected 1", dataValid); else passes++;
            checks++; if (count !== 5'(15 - i)) $display("[TB] FAIL drain_count: got %0d expected %0d", count, 15 - i); else passes++;
        end
        tick();
        readEn = 1'b0;
        checks++; if (underflow !== 1'b1) $display("[TB] FAIL drain_udf: got %b expected 1", underflow); else passes++;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL drain_empty: got %b expected 1", empty); else passes++;
        checks++; if (dataValid !== 1'b0) $display("[TB] FAIL drain_nopulse: got %b expected 0", dataValid); else passes++;
        checks++; if (dataOut !== 8'h0F) $display("[TB] FAIL drain_hold: got %h expected 0f", dataOut); else passes++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL drain_ovf_sticky: got %b expected 1", overflow); else passes++;
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        checks++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL clr_err: got %b expected 00", {overflow, underflow}); else passes++;
    endtask

    // Push+pop while full keeps count at 16; push+pop while empty only pushes.
    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            writeEn = 1'b1; dataIn = 8'(8'h20 + i);
            tick();
        end
        readEn = 1'b1; dataIn = 8'h55;
        tick();
        writeEn = 1'b0;
        checks++; if (count !== 5'd16) $display("[TB] FAIL sim_full_count: got %0d expected 16", count); else passes++;
        checks++; if (full !== 1'b1) $display("[TB] FAIL sim_full_flag: got %b expected 1", full); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL sim_full_ovf: got %b expected 0", overflow); else passes++;
        checks++; if (dataOut !== 8'h20) $display("[TB] FAIL sim_full_data: got %h expected 20", dataOut); else passes++;
        for (int i = 0; i < 16; i++) begin
            expByte = (i < 15) ? 8'(8'h21 + i) : 8'h55;
            tick();
            checks++; if (dataOut !== expByte) $display("[TB] FAIL sim_drain_data: got %h expected %h", dataOut, expByte); else passes++;
        end
        writeEn = 1'b1; dataIn = 8'h77;
        tick();
        writeEn = 1'b0;
        checks++; if (count !== 5'd1) $display("[TB] FAIL sim_empty_count: got %0d expected 1", count); else passes++;
        checks++; if (underflow !== 1'b1) $display("[TB] FAIL sim_empty_udf: got %b expected 1", underflow); else passes++;
        checks++; if (dataValid !== 1'b0) $display("[TB] FAIL sim_empty_valid: got %b expected 0", dataValid); else passes++;
        tick();
        readEn = 1'b0;
        checks++; if (dataOut !== 8'h77) $display("[TB] FAIL sim_empty_data: got %h expected 77", dataOut); else passes++;
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        checks++; if (underflow !== 1'b0) $display("[TB] FAIL sim_clr: got %b expected 0", underflow); else passes++;
    endtask

    // Forty push/pop pairs with three words in flight carry the pointers past the wrap.
    task automatic test_wrap();
        model.delete();
        for (int i = 0; i < 3; i++) begin
            writeEn = 1'b1; dataIn = 8'(8'h80 + i);
            model.push_back(dataIn);
            tick();
        end
        readEn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            dataIn = 8'(8'h83 + k);
            model.push_back(dataIn);
            tick();
            expByte = model.pop_front();
            checks++; if (dataOut !== expByte) $display("[TB] FAIL wrap_data: got %h expected %h", dataOut, expByte); else passes++;
            checks++; if (count !== 5'd3) $display("[TB] FAIL wrap_count: got %0d expected 3", count); else passes++;
            checks++; if (full !== 1'b0) $display("[TB] FAIL wrap_full: got %b expected 0", full); else passes++;
        end
        writeEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expByte = model.pop_front();
            checks++; if (dataOut !== expByte) $display("[TB] FAIL wrap_tail: got %h expected %h", dataOut, expByte); else passes++;
        end
        readEn = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) $display("[TB] FAIL wrap_empty: got %b expected 1", empty); else passes++;
    endtask

    // FWFT instance shows the head without a read and advances on a pop.
    task automatic test_fwft();
        fWriteEn = 1'b1; fDataIn = 8'h3C;
        tick();
        checks++; if (fDataOut !== 8'h3C) $display("[TB] FAIL fwft_first: got %h expected 3c", fDataOut); else passes++;
        checks++; if (fDataValid !== 1'b1) $display("[TB] FAIL fwft_valid: got %b expected 1", fDataValid); else passes++;
        fDataIn = 8'h5A;
        tick();
        fWriteEn = 1'b0;
        checks++; if (fDataOut !== 8'h3C) $display("[TB] FAIL fwft_hold: got %h expected 3c", fDataOut); else passes++;
        checks++; if (fCount !== 5'd2) $display("[TB] FAIL fwft_count: got %0d expected 2", fCount); else passes++;
        fReadEn = 1'b1;
        tick();
        checks++; if (fDataOut !== 8'h5A) $display("[TB] FAIL fwft_next: got %h expected 5a", fDataOut); else passes++;
        checks++; if (fDataValid !== 1'b1) $display("[TB] FAIL fwft_next_valid: got %b expected 1", fDataValid); else passes++;
        tick();
        fReadEn = 1'b0;
        checks++; if (fEmpty !== 1'b1) $display("[TB] FAIL fwft_empty: got %b expected 1", fEmpty); else passes++;
        checks++; if (fDataValid !== 1'b0) $display("[TB] FAIL fwft_empty_valid: got %b expected 0", fDataValid); else passes++;
    endtask

    // Asynchronous reset between edges with count 9 and overflow set, then reuse.
    task automatic test_reset_midop();
        writeEn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            dataIn = 8'(8'h40 + i);
            tick();
        end
        writeEn = 1'b0; readEn = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        readEn = 1'b0;
        checks++; if (count !== 5'd9) $display("[TB] FAIL mid_pre_count: got %0d expected 9", count); else passes++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL mid_pre_ovf: got %b expected 1", overflow); else passes++;
        checks++; if (dataOut !== 8'h46) $display("[TB] FAIL mid_pre_data: got %h expected 46", dataOut); else passes++;
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (count !== 5'd0) $display("[TB] FAIL mid_count: got %0d expected 0", count); else passes++;
        checks++; if ({empty, full} !== 2'b10) $display("[TB] FAIL mid_empty_full: got %b expected 10", {empty, full}); else passes++;
        checks++; if ({almostFull, almostEmpty} !== 2'b01) $display("[TB] FAIL mid_af_ae: got %b expected 01", {almostFull, almostEmpty}); else passes++;
        checks++; if (dataOut !== 8'h00) $display("[TB] FAIL mid_dout: got %h expected 00", dataOut); else passes++;
        checks++; if (dataValid !== 1'b0) $display("[TB] FAIL mid_dvalid: got %b expected 0", dataValid); else passes++;
        checks++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL mid_err: got %b expected 00", {overflow, underflow}); else passes++;
        @(negedge clk);
        rstN = 1'b1;
        writeEn = 1'b1; dataIn = 8'h11;
        tick();
        writeEn = 1'b0; readEn = 1'b1;
        tick();
        readEn = 1'b0;
        checks++; if (dataOut !== 8'h11) $display("[TB] FAIL post_rst_data: got %h expected 11", dataOut); else passes++;
        checks++; if (dataValid !== 1'b1) $display("[TB] FAIL post_rst_valid: got %b expected 1", dataValid); else passes++;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL post_rst_empty: got %b expected 1", empty); else passes++;
    endtask

    // Bound the whole run in case the design stalls the bench.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: hold reset, then run each scenario in order.
    initial begin
        checks = 0; passes = 0;
        rstN = 1'b0;
        writeEn = 1'b0; readEn = 1'b0; clrErr = 1'b0; dataIn = 8'h00;
        fWriteEn = 1'b0; fReadEn = 1'b0; fClrErr = 1'b0; fDataIn = 8'h00;
        #12;
        test_reset();
        @(negedge clk);
        rstN = 1'b1;
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_fwft();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
